// File: rtl/hw_status_reader_if.sv
// Bundle between the hardware-manager/PS side and the status reader.
// The master drives capture and PS control inputs; the slave is the reader.
interface hw_status_reader_if;
  logic [31:0] status_word;
  logic        ps_interrupt;
  logic        rd_en;
  logic        irq_ack;
  logic        clr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [8:0]  count;
  logic        overflow;
  logic [15:0] drop_count;
  logic        irq;
  logic [24:0] last_code;
  logic [2:0]  last_board;
  logic        halted;

  modport master (
    output status_word, ps_interrupt, rd_en, irq_ack, clr,
    input  rd_data, rd_valid, count, overflow, drop_count, irq,
           last_code, last_board, halted
  );

  modport slave (
    input  status_word, ps_interrupt, rd_en, irq_ack, clr,
    output rd_data, rd_valid, count, overflow, drop_count, irq,
           last_code, last_board, halted
  );
endinterface

// File: rtl/hw_status_reader.sv
// Captures hardware-manager status words on ps_interrupt rising edges into a
// first-word-fall-through FIFO read by the PS, with drop accounting and irq.
module hw_status_reader #(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  hw_status_reader_if.slave bus
);
  localparam int         PTR_W    = $clog2(DEPTH);
  localparam logic [8:0] FULL_CNT = 9'(DEPTH);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [8:0]       count_q;
  logic             int_p0;
  logic             overflow_q, irq_q, halted_q;
  logic [15:0]      drop_q;
  logic [24:0]      code_q;
  logic [2:0]       board_q;

  logic capture, full, empty, pop, wr, drop;

  // Capture edge detection and FIFO event decode (clr suppresses all events)
  always_comb begin
    capture = bus.ps_interrupt & ~int_p0;
    full    = (count_q == FULL_CNT);
    empty   = (count_q == 9'd0);
    pop     = bus.rd_en & ~empty & ~bus.clr;
    wr      = capture & (~full | pop) & ~bus.clr;
    drop    = capture & full & ~pop & ~bus.clr;
  end

  // Storage is data only and carries no reset
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= bus.status_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_p0     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= 9'd0;
      overflow_q <= 1'b0;
      drop_q     <= 16'd0;
      irq_q      <= 1'b0;
      code_q     <= 25'd0;
      board_q    <= 3'd0;
      halted_q   <= 1'b0;
    end else begin
      int_p0 <= bus.ps_interrupt;
      if (bus.clr) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count_q    <= 9'd0;
        overflow_q <= 1'b0;
        drop_q     <= 16'd0;
        irq_q      <= 1'b0;
        code_q     <= 25'd0;
        board_q    <= 3'd0;
        halted_q   <= 1'b0;
      end else begin
        if (wr)  wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({wr, pop})
          2'b10:   count_q <= count_q + 9'd1;
          2'b01:   count_q <= count_q - 9'd1;
          default: count_q <= count_q;
        endcase
        if (drop) begin
          overflow_q <= 1'b1;
          drop_q     <= sat_inc16(drop_q);
        end
        // Dropped captures still refresh the most-recent status view
        if (capture) begin
          code_q   <= bus.status_word[28:4];
          board_q  <= bus.status_word[31:29];
          halted_q <= (bus.status_word[3:0] == 4'd8);
        end
        if (capture)          irq_q <= 1'b1;
        else if (bus.irq_ack) irq_q <= 1'b0;
      end
    end
  end

  assign bus.rd_data    = mem[rd_ptr];
  assign bus.rd_valid   = ~empty;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_q;
  assign bus.irq        = irq_q;
  assign bus.last_code  = code_q;
  assign bus.last_board = board_q;
  assign bus.halted     = halted_q;
endmodule

// File: doc/hw_status_reader.md
HW_STATUS_READER -- requirements
Module: hw_status_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of status-word entries, legal power of two 2..256.
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port status_word  input  32  hardware-manager status: [31:29] board_num, [28:4] status_code, [3:0] state.
REQ-005 SHALL have port ps_interrupt  input  1  hardware-manager interrupt; status_word is valid in any cycle it is high.
REQ-006 SHALL have port rd_en  input  1  PS pop request for head entry.
REQ-007 SHALL have port irq_ack  input  1  PS acknowledge, clears irq.
REQ-008 SHALL have port clr  input  1  synchronous clear of FIFO, flags and counters.
REQ-009 SHALL have port rd_data  output  32  head entry of FIFO.
REQ-010 SHALL have port rd_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port count  output  9  number of stored entries, 0..DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky: at least one capture dropped.
REQ-013 SHALL have port drop_count  output  16  dropped captures, saturating.
REQ-014 SHALL have port irq  output  1  level interrupt to PS.
REQ-015 SHALL have port last_code  output  25  status_code of most recent capture.
REQ-016 SHALL have port last_board  output  3  board_num of most recent capture.
REQ-017 SHALL have port halted  output  1  most recent captured state field equals 4'd8 (HALTED).

Function
REQ-018 SHALL register ps_interrupt and define a capture event as ps_interrupt high while its registered value is low (rising edge); a held-high ps_interrupt is one capture.
REQ-019 SHALL sample status_word in the capture-event cycle, not one cycle later.
REQ-020 SHALL write the captured word into a DEPTH-entry circular FIFO when not full; write pointer wraps from DEPTH-1 to 0.
REQ-021 SHALL present rd_data first-word-fall-through: rd_data equals the oldest entry whenever rd_valid is 1; rd_data is don't-care when empty.
REQ-022 SHALL pop the head on rd_en when rd_valid is 1; rd_en while empty is ignored with no pointer change.
REQ-023 SHALL give one-cycle latency: capture in cycle N makes count and rd_valid reflect the write in cycle N+1.
REQ-024 SHALL, on simultaneous capture and pop when not full and not empty, write and pop both, count unchanged.
REQ-025 SHALL, on simultaneous capture and pop when empty, write the word and ignore the pop; count becomes 1.
REQ-026 SHALL, on simultaneous capture and pop when full, pop and write both; no drop.
REQ-027 SHALL, on capture when full without pop, discard the word, set overflow, increment drop_count saturating at 16'hFFFF.
REQ-028 SHALL update last_code, last_board and halted on every capture, including dropped ones.
REQ-029 SHALL set irq in the cycle after any capture (written or dropped) and clear it in the cycle after irq_ack; capture and irq_ack in the same cycle leave irq = 1.
REQ-030 SHALL give clr priority over all other events: in the next cycle count = 0, rd_valid = 0, overflow = 0, drop_count = 0, irq = 0, last_code = 0, last_board = 0, halted = 0; a capture in the clr cycle is lost.
REQ-031 SHALL keep count arithmetic 9-bit so count = DEPTH is representable for DEPTH = 256.

Reset
REQ-032 SHALL, while rst is high, asynchronously force rd_valid = 0, count = 0, overflow = 0, drop_count = 0, irq = 0, last_code = 0, last_board = 0, halted = 0, both pointers = 0, registered ps_interrupt = 0.
REQ-033 SHALL, on reset during operation, discard all stored entries; a ps_interrupt already high at reset release counts as a capture on the first clock after release.

Verification
REQ-034 SHALL pass: single pulse with status_word = 32'h2000_00B8 -> next cycle count = 1, rd_valid = 1, rd_data = 32'h2000_00B8, last_code = 25'd11, last_board = 3'd1, halted = 1, irq = 1.
REQ-035 SHALL pass: ps_interrupt held high 5 cycles -> exactly one entry stored, count = 1.
REQ-036 SHALL pass: DEPTH = 16, 17 separated pulses, no reads -> count = 16, overflow = 1, drop_count = 1, last_code from the 17th word, rd_data from the 1st word.
REQ-037 SHALL pass: full FIFO, capture and rd_en in the same cycle -> count stays 16, overflow = 0, new word at tail; 16 pops return words 2..17 in order.
REQ-038 SHALL pass: capture and irq_ack in the same cycle -> irq = 1; irq_ack alone next cycle -> irq = 0; rd_en while empty -> count stays 0.
REQ-039 SHALL pass: clr asserted with a simultaneous capture on a 3-entry FIFO -> next cycle count = 0, irq = 0, overflow = 0, last_code = 0.
